// File: rtl/booth_pkg.sv
// Shared types and the Booth op decoder for the sequential Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} booth_state_t;

  typedef enum logic [1:0] {BOOTH_NOP, BOOTH_ADD, BOOTH_SUB} booth_op_t;

  // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], Q_1}.
  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    booth_op_t op;
    case ({q0, q_1})
      2'b10:   op = BOOTH_SUB;
      2'b01:   op = BOOTH_ADD;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational add/sub step unit: output_c = a+b, a-b or a depending on op.
module booth_addsub
  import booth_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  booth_op_t        op,
  output logic [WIDTH-1:0] output_c
);

  always_comb begin
    output_c = input_a;
    case (op)
      BOOTH_ADD: output_c = input_a + input_b;
      BOOTH_SUB: output_c = input_a - input_b;
      default:   output_c = input_a;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake.
// Define BOOTH_EARLY_TERM_EN to finish CALC as soon as the remaining steps are all no-ops.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int REG_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ctl_start,
  input  logic [REG_WIDTH-1:0]   input_a,
  input  logic [REG_WIDTH-1:0]   input_b,
  output logic                   ctl_busy,
  output logic                   ctl_done,
  output logic [2*REG_WIDTH-1:0] output_c
);

  localparam int W  = REG_WIDTH;
  localparam int CW = $clog2(W + 1);

  booth_state_t   state_q, state_d;
  logic [W-1:0]   m_q, m_d;
  logic [W:0]     a_q, a_d;
  logic [W-1:0]   q_q, q_d;
  logic           q1_q, q1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] c_q, c_d;

  booth_op_t      op;
  logic [W:0]     sum;
  logic [2*W+1:0] step_cat;
  logic           early_hit;
  logic [2*W:0]   aq_sh;

  // A is one bit wider than M so that A - (-2^(W-1)) cannot overflow.
  assign op = booth_decode(q_q[0], q1_q);

  booth_addsub #(.WIDTH(W + 1)) u_addsub (
    .input_a  (a_q),
    .input_b  ({m_q[W-1], m_q}),
    .op       (op),
    .output_c (sum)
  );

  assign step_cat = {sum, q_q, q1_q};

`ifdef BOOTH_EARLY_TERM_EN
  // Remaining steps are all no-ops when Q[count-1:0] and Q_1 share one value.
  always_comb begin
    early_hit = 1'b1;
    for (int i = 0; i < W; i++) begin
      if ((i < int'(cnt_q)) && (q_q[i] != q1_q)) early_hit = 1'b0;
    end
    aq_sh = $signed({a_q, q_q}) >>> cnt_q;
  end
`else
  assign early_hit = 1'b0;
  assign aq_sh     = '0;
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (ctl_start) begin
          m_d     = input_a;
          q_d     = input_b;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = CW'(W);
          state_d = CALC;
        end
      end
      CALC: begin
        if (early_hit) begin
          {a_d, q_d} = aq_sh;
          q1_d       = 1'b0;
          cnt_d      = '0;
          c_d        = {a_d[W-1:0], q_d};
          state_d    = DONE;
        end else begin
          // Arithmetic shift of {A,Q,Q_1} using the post-op A.
          {a_d, q_d, q1_d} = {step_cat[2*W+1], step_cat[2*W+1:1]};
          cnt_d            = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            c_d     = {a_d[W-1:0], q_d};
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
    end
  end

  assign ctl_busy = (state_q == CALC);
  assign ctl_done = (state_q == DONE);
  assign output_c = c_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq (REG_WIDTH=8) against an arithmetic reference model.
module tb_booth_mul_seq;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           ctl_start;
  logic [W-1:0]   input_a;
  logic [W-1:0]   input_b;
  logic           ctl_busy;
  logic           ctl_done;
  logic [2*W-1:0] output_c;

  logic [2*W-1:0] exp_q[$];
  int             cyc_q[$];
  logic [2*W-1:0] last_c;
  int             n_total;
  int             n_bad;

  booth_mul_seq #(.REG_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ctl_start (ctl_start),
    .input_a   (input_a),
    .input_b   (input_b),
    .ctl_busy  (ctl_busy),
    .ctl_done  (ctl_done),
    .output_c  (output_c)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: true signed product truncated to 2W bits.
  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[2*W-1:0];
  endfunction

  // Number of CALC cycles: fixed W, or with early termination the first step j at
  // which multiplier bits b[W-1:j] and b[j-1] (b[-1]=0) are all equal.
  function automatic int ref_cycles(input logic [W-1:0] b);
`ifdef BOOTH_EARLY_TERM_EN
    logic [W:0] ext;
    bit         same;
    ext = {b, 1'b0};
    for (int j = 0; j < W; j++) begin
      same = 1'b1;
      for (int k = j; k <= W; k++) if (ext[k] != ext[j]) same = 1'b0;
      if (same) return j + 1;
    end
`endif
    return W;
  endfunction

  // driver: called just after a negedge; start is sampled at the next posedge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    ctl_start = 1'b1;
    input_a   = a;
    input_b   = b;
    exp_q.push_back(ref_product(a, b));
    cyc_q.push_back(ref_cycles(b));
  endtask

  // Walks the CALC cycles and the DONE cycle; poke>0 pulses a stray start in CALC cycle poke.
  task automatic calc_and_check(input int poke);
    int             n;
    logic [2*W-1:0] e;
    n = cyc_q.pop_front();
    e = exp_q.pop_front();
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check("busy_in_calc", {31'd0, ctl_busy}, 32'd1);
      check("no_done_in_calc", {31'd0, ctl_done}, 32'd0);
      check("c_hold_in_calc", {16'd0, output_c}, {16'd0, last_c});
      ctl_start = (k == poke) && (k < n);
      if (ctl_start) begin
        input_a = W'($urandom_range(0, 255));
        input_b = W'($urandom_range(0, 255));
      end
    end
    @(negedge clk);
    check("done_pulse", {31'd0, ctl_done}, 32'd1);
    check("busy_off_done", {31'd0, ctl_busy}, 32'd0);
    check("product", {16'd0, output_c}, {16'd0, e});
    last_c    = e;
    ctl_start = 1'b0;
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("done_one_cycle", {31'd0, ctl_done}, 32'd0);
    check("busy_idle", {31'd0, ctl_busy}, 32'd0);
    check("c_hold_idle", {16'd0, output_c}, {16'd0, last_c});
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(a, b);
    calc_and_check(0);
    idle_check();
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    n_total   = 0;
    n_bad     = 0;
    last_c    = '0;
    rst       = 1'b1;
    ctl_start = 1'b0;
    input_a   = '0;
    input_b   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, ctl_busy}, 32'd0);
    check("rst_done", {31'd0, ctl_done}, 32'd0);
    check("rst_c", {16'd0, output_c}, 32'd0);
    rst = 1'b0;
    idle_check();

    // directed: basic, signed, most-negative corner
    run_op(8'd3, 8'd5);
    run_op(8'hF9, 8'd3);
    run_op(8'h80, 8'h80);
    run_op(8'h7F, 8'h80);
    run_op(8'hFF, 8'hFF);

    // stray start during CALC, then back-to-back start in the DONE cycle
    start_op(8'd3, 8'd5);
    calc_and_check(4);
    start_op(8'd2, 8'd3);
    calc_and_check(0);
    idle_check();

    // early-termination shapes (same product in either build)
    run_op(8'd5, 8'd1);
    run_op(8'd5, 8'd0);
    run_op(8'd9, 8'hFF);

    // reset mid-operation: aborted op never produces a done pulse
    start_op(8'd17, 8'h55);
    void'(exp_q.pop_front());
    void'(cyc_q.pop_front());
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("busy_before_abort", {31'd0, ctl_busy}, 32'd1);
      ctl_start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    last_c = '0;
    check("abort_busy", {31'd0, ctl_busy}, 32'd0);
    check("abort_done", {31'd0, ctl_done}, 32'd0);
    check("abort_c", {16'd0, output_c}, 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("no_done_after_abort", {31'd0, ctl_done}, 32'd0);
    end

    // random, mixing idle gaps and back-to-back starts
    start_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    for (int i = 0; i < 40; i++) begin
      calc_and_check(($urandom_range(0, 3) == 0) ? 2 : 0);
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        start_op(ra, rb);
      end else begin
        idle_check();
        start_op(ra, rb);
      end
    end
    calc_and_check(0);
    idle_check();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
